// File: rtl/ahb_apb_req_arbiter.sv
// Two-requester round-robin arbiter that turns single requests into one
// non-pipelined AHB-Lite transfer at a time towards an AHB-to-APB bridge.
module ahb_apb_req_arbiter #(
  parameter logic [6:0] HPROT_VAL   = 7'b0000011,
  parameter logic       HNONSEC_VAL = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic [14:0] ADDR0,
  input  logic [14:0] ADDR1,
  input  logic        WRITE0,
  input  logic        WRITE1,
  input  logic [1:0]  SIZE0,
  input  logic [1:0]  SIZE1,
  input  logic [31:0] WDATA0,
  input  logic [31:0] WDATA1,
  output logic        ACK0,
  output logic        ACK1,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic [1:0]  GNT,
  output logic        HSEL,
  output logic [1:0]  HTRANS,
  output logic [14:0] HADDR,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  output logic [6:0]  HPROT,
  output logic        HNONSEC,
  output logic        HREADY,
  input  logic        HREADYOUT,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_q;
  logic [1:0]  gnt_q;
  logic        last_q;
  logic        ack0_q, ack1_q, err_q;
  logic [31:0] rdata_q;
  logic        hsel_q, hwrite_q;
  logic [1:0]  htrans_q;
  logic [14:0] haddr_q;
  logic [2:0]  hsize_q;
  logic [31:0] hwdata_q;

  logic        pick1_d;
  logic [14:0] sel_addr_d;
  logic [1:0]  sel_size_d;
  logic        sel_write_d;
  logic [31:0] sel_wdata_d;
  logic        sel_illegal_d;

  // Size/alignment combinations the bridge cannot carry are answered locally.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lsb);
    return (size == 2'b11) || (size == 2'b01 && lsb[0]) || (size == 2'b10 && lsb != 2'b00);
  endfunction

  // last_q = 1 means requester 1 was granted last, so requester 0 wins a tie.
  always_comb begin
    pick1_d       = REQ1 && (!REQ0 || !last_q);
    sel_addr_d    = pick1_d ? ADDR1  : ADDR0;
    sel_size_d    = pick1_d ? SIZE1  : SIZE0;
    sel_write_d   = pick1_d ? WRITE1 : WRITE0;
    sel_wdata_d   = pick1_d ? WDATA1 : WDATA0;
    sel_illegal_d = is_illegal(sel_size_d, sel_addr_d[1:0]);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      gnt_q    <= 2'b00;
      last_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      hsel_q   <= 1'b0;
      htrans_q <= 2'b00;
      haddr_q  <= 15'h0;
      hsize_q  <= 3'b000;
      hwrite_q <= 1'b0;
      hwdata_q <= 32'h0;
    end else begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      hsel_q   <= 1'b0;
      htrans_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (REQ0 || REQ1) begin
            gnt_q  <= pick1_d ? 2'b10 : 2'b01;
            last_q <= pick1_d;
            if (sel_illegal_d) begin
              err_q   <= 1'b1;
              rdata_q <= 32'h0;
              ack0_q  <= !pick1_d;
              ack1_q  <= pick1_d;
              state_q <= RESP;
            end else begin
              haddr_q  <= sel_addr_d;
              hsize_q  <= {1'b0, sel_size_d};
              hwrite_q <= sel_write_d;
              hwdata_q <= sel_wdata_d;
              hsel_q   <= 1'b1;
              htrans_q <= 2'b10;
              state_q  <= ADDR;
            end
          end
        end
        ADDR: state_q <= DATA;
        // A two-cycle error response is simply waited out via HREADYOUT.
        DATA: begin
          if (HREADYOUT) begin
            err_q   <= HRESP;
            rdata_q <= hwrite_q ? 32'h0 : HRDATA;
            ack0_q  <= gnt_q[0];
            ack1_q  <= gnt_q[1];
            state_q <= RESP;
          end
        end
        RESP: begin
          gnt_q   <= 2'b00;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ACK0    = ack0_q;
  assign ACK1    = ack1_q;
  assign ERR     = err_q;
  assign RDATA   = rdata_q;
  assign GNT     = gnt_q;
  assign HSEL    = hsel_q;
  assign HTRANS  = htrans_q;
  assign HADDR   = haddr_q;
  assign HSIZE   = hsize_q;
  assign HWRITE  = hwrite_q;
  assign HWDATA  = hwdata_q;
  assign HPROT   = HPROT_VAL;
  assign HNONSEC = HNONSEC_VAL;
  assign HREADY  = HREADYOUT;

endmodule
